selector_frame_packer: RTL and testbench

SELECTOR_FRAME_PACKER -- requirements
Module: selector_frame_packer

---
 rtl/selector_frame_packer.sv | 127 ++++++++++++
 tb/tb_selector_frame_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/selector_frame_packer.sv
// Packs four in-order selector bytes into a 32-bit frame with a registered byte sum.
// Optional FRAME_PACKER_PARITY_EN adds a registered even-parity output for the frame.
module selector_frame_packer #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               in_valid,
  input  logic [1:0]         select,
  input  logic [7:0]         result,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [LANES*8-1:0] frame,
  output logic [9:0]         frame_sum,
  output logic               seq_err,
  output logic [7:0]         drop_cnt
`ifdef FRAME_PACKER_PARITY_EN
  ,
  output logic               frame_parity
`endif
);

  logic [1:0]         exp_lane_q, exp_lane_d;
  logic [7:0]         stage_q [LANES];
  logic [7:0]         stage_d [LANES];
  logic               seq_err_q, seq_err_d;
  logic               out_valid_q, out_valid_d;
  logic [LANES*8-1:0] frame_q, frame_d;
  logic [9:0]         sum_q, sum_d;
  logic [7:0]         drop_q, drop_d;
  logic               complete;
  logic               load;
  logic [LANES*8-1:0] new_frame;

  function automatic logic [9:0] lane_sum(input logic [LANES*8-1:0] f);
    logic [9:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++) s = s + 10'(f[i*8 +: 8]);
    return s;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Staging: an out-of-order lane restarts the frame; a lane 0 restart keeps its byte.
  always_comb begin
    exp_lane_d = exp_lane_q;
    seq_err_d  = 1'b0;
    complete   = 1'b0;
    for (int i = 0; i < LANES; i++) stage_d[i] = stage_q[i];
    if (in_valid) begin
      if (select == exp_lane_q) begin
        stage_d[select] = result;
        exp_lane_d      = exp_lane_q + 2'd1;
        complete        = (select == 2'd3);
      end else begin
        seq_err_d  = 1'b1;
        exp_lane_d = 2'd0;
        for (int i = 0; i < LANES; i++) stage_d[i] = 8'h00;
        if (select == 2'd0) begin
          stage_d[0] = result;
          exp_lane_d = 2'd1;
        end
      end
    end
    new_frame = '0;
    for (int i = 0; i < LANES; i++) new_frame[i*8 +: 8] = stage_d[i];
  end

  // Output register: a completed frame loads if the slot is empty or draining, else it is dropped.
  always_comb begin
    out_valid_d = out_valid_q;
    frame_d     = frame_q;
    sum_d       = sum_q;
    drop_d      = drop_q;
    load        = 1'b0;
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        load        = 1'b1;
        out_valid_d = 1'b1;
        frame_d     = new_frame;
        sum_d       = lane_sum(new_frame);
      end else begin
        drop_d = sat_inc(drop_q);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      exp_lane_q  <= 2'd0;
      seq_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      frame_q     <= '0;
      sum_q       <= '0;
      drop_q      <= '0;
      for (int i = 0; i < LANES; i++) stage_q[i] <= 8'h00;
    end else begin
      exp_lane_q  <= exp_lane_d;
      seq_err_q   <= seq_err_d;
      out_valid_q <= out_valid_d;
      frame_q     <= frame_d;
      sum_q       <= sum_d;
      drop_q      <= drop_d;
      for (int i = 0; i < LANES; i++) stage_q[i] <= stage_d[i];
    end
  end

`ifdef FRAME_PACKER_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) parity_q <= 1'b0;
    else if (load) parity_q <= ^new_frame;
  end
  assign frame_parity = parity_q;
`endif

  assign out_valid = out_valid_q;
  assign frame     = frame_q;
  assign frame_sum = sum_q;
  assign seq_err   = seq_err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_selector_frame_packer.sv
// Scoreboard bench for selector_frame_packer: stimulus pushes expected frames, a monitor pops on transfer.
// Builds with or without FRAME_PACKER_PARITY_EN.
module tb_selector_frame_packer;
  logic        clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [1:0]  select;
  logic [7:0]  result;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] frame;
  logic [9:0]  frame_sum;
  logic        seq_err;
  logic [7:0]  drop_cnt;
`ifdef FRAME_PACKER_PARITY_EN
  logic        frame_parity;
`endif

  selector_frame_packer #(.LANES(4)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .select(select), .result(result),
    .out_ready(out_ready), .out_valid(out_valid), .frame(frame), .frame_sum(frame_sum),
    .seq_err(seq_err), .drop_cnt(drop_cnt)
`ifdef FRAME_PACKER_PARITY_EN
    , .frame_parity(frame_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] f;
    logic [9:0]  s;
  } exp_t;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] r);
    in_valid = v;
    select   = s;
    result   = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lanes4(input logic [31:0] f, input logic [9:0] s, input bit expect_out);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && expect_out) exp_q.push_back('{f: f, s: s});
      drive(1'b1, i[1:0], f[i*8 +: 8]);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever out_valid and out_ready are high here.
  always @(negedge clk) begin
    exp_t e;
    if (!Reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame got=%0h want=none", frame);
      end else begin
        e = exp_q.pop_front();
        if (frame !== e.f || frame_sum !== e.s) begin
          errors++;
          $display("FAIL frame_out got=%0h/%0d want=%0h/%0d", frame, frame_sum, e.f, e.s);
        end
`ifdef FRAME_PACKER_PARITY_EN
        checks++;
        if (frame_parity !== ^e.f) begin
          errors++;
          $display("FAIL parity got=%0b want=%0b", frame_parity, ^e.f);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; in_valid = 1'b0; select = 2'd0; result = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_frame", frame, 0);
    chk("rst_sum", 32'(frame_sum), 0);
    chk("rst_seq_err", 32'(seq_err), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    Reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame, latency one clock after lane 3
    lanes4(32'h04030201, 10'd10, 1'b1);
    chk("lat1_valid", 32'(out_valid), 1);
    drive(1'b0, 2'd0, 8'h00);
    chk("pop_falls", 32'(out_valid), 0);

    // Maximum bytes
    lanes4(32'hFFFFFFFF, 10'd1020, 1'b1);
    drive(1'b0, 2'd0, 8'h00);

    // Idle cycles in the middle of a frame, with a stray select while invalid
    drive(1'b1, 2'd0, 8'hD0);
    drive(1'b0, 2'd2, 8'h55);
    chk("idle_no_seq_err", 32'(seq_err), 0);
    drive(1'b1, 2'd1, 8'hC0);
    drive(1'b0, 2'd3, 8'h11);
    drive(1'b1, 2'd2, 8'hB0);
    exp_q.push_back('{f: 32'hA0B0C0D0, s: 10'd736});
    drive(1'b1, 2'd3, 8'hA0);
    drive(1'b0, 2'd0, 8'h00);

    // Lane order 0,1,3 aborts with no frame, then a clean frame
    drive(1'b1, 2'd0, 8'hAA);
    drive(1'b1, 2'd1, 8'hBB);
    drive(1'b1, 2'd3, 8'hCC);
    chk("seq_err_pulse", 32'(seq_err), 1);
    chk("seq_err_no_frame", 32'(out_valid), 0);
    drive(1'b0, 2'd0, 8'h00);
    chk("seq_err_one_cycle", 32'(seq_err), 0);
    lanes4(32'h13121110, 10'd70, 1'b1);
    drive(1'b0, 2'd0, 8'h00);

    // Out-of-order lane 0 restarts with its byte kept
    drive(1'b1, 2'd0, 8'h77);
    drive(1'b1, 2'd1, 8'h66);
    drive(1'b1, 2'd0, 8'h21);
    chk("restart_seq_err", 32'(seq_err), 1);
    drive(1'b1, 2'd1, 8'h22);
    drive(1'b1, 2'd2, 8'h23);
    exp_q.push_back('{f: 32'h24232221, s: 10'd138});
    drive(1'b1, 2'd3, 8'h24);
    drive(1'b0, 2'd0, 8'h00);

    // Backpressure: second frame dropped, first held
    out_ready = 1'b0;
    lanes4(32'h04030201, 10'd10, 1'b1);
    lanes4(32'h08070605, 10'd26, 1'b0);
    chk("hold_frame", frame, 32'h04030201);
    chk("hold_sum", 32'(frame_sum), 10);
    chk("hold_valid", 32'(out_valid), 1);
    chk("drop_one", 32'(drop_cnt), 1);
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 8'h00);
    chk("bp_pop_falls", 32'(out_valid), 0);

    // Completion in the same cycle as a pop
    out_ready = 1'b0;
    lanes4(32'h44332211, 10'd170, 1'b1);
    drive(1'b1, 2'd0, 8'h55);
    drive(1'b1, 2'd1, 8'h66);
    drive(1'b1, 2'd2, 8'h77);
    out_ready = 1'b1;
    exp_q.push_back('{f: 32'h88776655, s: 10'd442});
    drive(1'b1, 2'd3, 8'h88);
    chk("b2b_valid", 32'(out_valid), 1);
    chk("b2b_frame", frame, 32'h88776655);
    chk("b2b_no_drop", 32'(drop_cnt), 1);
    drive(1'b0, 2'd0, 8'h00);
    chk("b2b_falls", 32'(out_valid), 0);

    // Drop counter saturation
    #2; Reset = 1'b1; #1; Reset = 1'b0;
    chk("rst2_drop", 32'(drop_cnt), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    lanes4(32'h01010101, 10'd4, 1'b1);
    for (int k = 0; k < 300; k++) begin
      lanes4(32'h02020202, 10'd8, 1'b0);
      if (k == 253) chk("drop_254", 32'(drop_cnt), 254);
    end
    chk("drop_sat", 32'(drop_cnt), 255);
    chk("sat_hold_frame", frame, 32'h01010101);
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 8'h00);
    chk("sat_falls", 32'(out_valid), 0);

    // Asynchronous reset mid-frame
    out_ready = 1'b0;
    lanes4(32'h0D0C0B0A, 10'd46, 1'b1);
    lanes4(32'h0F0F0F0F, 10'd60, 1'b0);
    drive(1'b1, 2'd0, 8'hEE);
    drive(1'b1, 2'd1, 8'hEF);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_frame", frame, 0);
    chk("async_sum", 32'(frame_sum), 0);
    chk("async_drop", 32'(drop_cnt), 0);
    chk("async_seq_err", 32'(seq_err), 0);
    exp_q.delete();
    @(negedge clk);
    #1;
    Reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'd2, 8'h99);
    chk("post_rst_expects_lane0", 32'(seq_err), 1);
    lanes4(32'h3C3B3A39, 10'd234, 1'b1);
    drive(1'b0, 2'd0, 8'h00);
    drive(1'b0, 2'd0, 8'h00);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
